// File: rtl/pcpu_pkg.sv
// Shared pipeline constants and types for the operand fetch stage.
// REG_ZERO is the hard-wired zero register, which never takes part in forwarding.
package pcpu_pkg;

  localparam int PCPU_DW = 32;
  localparam int PCPU_AW = 5;
  localparam int PCPU_CW = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SEL_RF   = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_WB   = 2'd2,
    SEL_ZERO = 2'd3
  } opnd_sel_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/operand_fwd_sel.sv
// Per-operand producer match, hazard detect and operand select.
// OPERAND_FWD_EN defined: forward from MEM (non-load) and WB; otherwise any match stalls.
module operand_fwd_sel
  import pcpu_pkg::*;
#(
  parameter int DW = PCPU_DW,
  parameter int AW = PCPU_AW
) (
  input  logic [AW-1:0] src,
  input  logic          src_used,
  input  logic          ex_valid,
  input  logic          ex_wen,
  input  logic [AW-1:0] ex_dst,
  input  logic          mem_wen,
  input  logic [AW-1:0] mem_dst,
  input  logic          mem_isload,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_wen,
  input  logic [AW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  input  logic [DW-1:0] rf_rdata,
  output logic [DW-1:0] opnd,
  output logic          hazard
);

  logic      nonzero;
  logic      match_ex;
  logic      match_mem;
  logic      match_wb;
  logic      mem_load_hit;
  logic      mem_alu_hit;
  opnd_sel_e sel;

  always_comb begin
    nonzero      = (src != AW'(REG_ZERO));
    match_ex     = src_used & nonzero & ex_valid & ex_wen & (ex_dst == src);
    match_mem    = src_used & nonzero & mem_wen & (mem_dst == src);
    match_wb     = src_used & nonzero & wb_wen & (wb_dst == src);
    // A load in MEM has no data yet; an ALU result in MEM does.
    mem_load_hit = match_mem & mem_isload;
    mem_alu_hit  = match_mem & ~mem_isload;

`ifdef OPERAND_FWD_EN
    hazard = match_ex | mem_load_hit;
    if (!nonzero) begin
      sel = SEL_ZERO;
    end else if (mem_alu_hit) begin
      sel = SEL_MEM;
    end else if (match_wb) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
`else
    hazard = match_ex | mem_load_hit | mem_alu_hit | match_wb;
    sel    = nonzero ? SEL_RF : SEL_ZERO;
`endif

    case (sel)
      SEL_MEM:  opnd = mem_data;
      SEL_WB:   opnd = wb_data;
      SEL_ZERO: opnd = '0;
      default:  opnd = rf_rdata;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// ID->EX operand fetch: register-file read, hazard stall, forwarding, ID/EX register.
// Forwarding from MEM/WB is present only when OPERAND_FWD_EN is defined.
module operand_fetch
  import pcpu_pkg::*;
#(
  parameter int DW = PCPU_DW,
  parameter int AW = PCPU_AW,
  parameter int CW = PCPU_CW
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          id_valid,
  output logic          id_ready,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rea,
  input  logic          id_reb,
  input  logic [AW-1:0] id_dst,
  input  logic          id_wen,
  input  logic          id_isload,
  input  logic [CW-1:0] id_ctl,

  output logic [AW-1:0] rf_raddra,
  output logic [AW-1:0] rf_raddrb,
  output logic          rf_rea,
  output logic          rf_reb,
  input  logic [DW-1:0] rf_rdataa,
  input  logic [DW-1:0] rf_rdatab,

  input  logic          mem_wen,
  input  logic [AW-1:0] mem_dst,
  input  logic          mem_isload,
  input  logic [DW-1:0] mem_data,

  input  logic          wb_wen,
  input  logic [AW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,

  input  logic          ex_stall,
  input  logic          flush,

  output logic          ex_valid,
  output logic [DW-1:0] ex_opa,
  output logic [DW-1:0] ex_opb,
  output logic [AW-1:0] ex_dst,
  output logic          ex_wen,
  output logic          ex_isload,
  output logic [CW-1:0] ex_ctl,
  output logic [31:0]   stall_cnt
);

  logic          ex_valid_q,  ex_valid_d;
  logic [DW-1:0] ex_opa_q,    ex_opa_d;
  logic [DW-1:0] ex_opb_q,    ex_opb_d;
  logic [AW-1:0] ex_dst_q,    ex_dst_d;
  logic          ex_wen_q,    ex_wen_d;
  logic          ex_isload_q, ex_isload_d;
  logic [CW-1:0] ex_ctl_q,    ex_ctl_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;
  logic          hazard_a;
  logic          hazard_b;
  logic          hazard;

  assign rf_raddra = id_rs;
  assign rf_raddrb = id_rt;
  assign rf_rea    = id_valid & id_rea;
  assign rf_reb    = id_valid & id_reb;

  operand_fwd_sel #(.DW(DW), .AW(AW)) u_sel_a (
    .src        (id_rs),
    .src_used   (id_rea),
    .ex_valid   (ex_valid_q),
    .ex_wen     (ex_wen_q),
    .ex_dst     (ex_dst_q),
    .mem_wen    (mem_wen),
    .mem_dst    (mem_dst),
    .mem_isload (mem_isload),
    .mem_data   (mem_data),
    .wb_wen     (wb_wen),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .rf_rdata   (rf_rdataa),
    .opnd       (opnd_a),
    .hazard     (hazard_a)
  );

  operand_fwd_sel #(.DW(DW), .AW(AW)) u_sel_b (
    .src        (id_rt),
    .src_used   (id_reb),
    .ex_valid   (ex_valid_q),
    .ex_wen     (ex_wen_q),
    .ex_dst     (ex_dst_q),
    .mem_wen    (mem_wen),
    .mem_dst    (mem_dst),
    .mem_isload (mem_isload),
    .mem_data   (mem_data),
    .wb_wen     (wb_wen),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .rf_rdata   (rf_rdatab),
    .opnd       (opnd_b),
    .hazard     (hazard_b)
  );

  assign hazard   = hazard_a | hazard_b;
  assign id_ready = ~ex_stall & ~hazard;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_opa_d    = ex_opa_q;
    ex_opb_d    = ex_opb_q;
    ex_dst_d    = ex_dst_q;
    ex_wen_d    = ex_wen_q;
    ex_isload_d = ex_isload_q;
    ex_ctl_d    = ex_ctl_q;
    stall_cnt_d = stall_cnt_q;

    // Bubbles clear only the qualifiers; payload fields keep their last value.
    if (flush || (!ex_stall && hazard)) begin
      ex_valid_d  = 1'b0;
      ex_wen_d    = 1'b0;
      ex_isload_d = 1'b0;
    end else if (!ex_stall) begin
      ex_valid_d  = id_valid;
      ex_opa_d    = opnd_a;
      ex_opb_d    = opnd_b;
      ex_dst_d    = id_dst;
      ex_wen_d    = id_wen & id_valid;
      ex_isload_d = id_isload & id_valid;
      ex_ctl_d    = id_ctl;
    end

    if (id_valid && hazard && !ex_stall && !flush) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_opa_q    <= '0;
      ex_opb_q    <= '0;
      ex_dst_q    <= '0;
      ex_wen_q    <= 1'b0;
      ex_isload_q <= 1'b0;
      ex_ctl_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_opa_q    <= ex_opa_d;
      ex_opb_q    <= ex_opb_d;
      ex_dst_q    <= ex_dst_d;
      ex_wen_q    <= ex_wen_d;
      ex_isload_q <= ex_isload_d;
      ex_ctl_q    <= ex_ctl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_opa    = ex_opa_q;
  assign ex_opb    = ex_opb_q;
  assign ex_dst    = ex_dst_q;
  assign ex_wen    = ex_wen_q;
  assign ex_isload = ex_isload_q;
  assign ex_ctl    = ex_ctl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and random bench for operand_fetch against a producer-list reference model.
// Expectations follow the OPERAND_FWD_EN setting of the build.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_rea, id_reb, id_wen, id_isload;
  logic [15:0] id_ctl;
  logic [4:0]  rf_raddra, rf_raddrb;
  logic        rf_rea, rf_reb;
  logic [31:0] rf_rdataa, rf_rdatab;
  logic        mem_wen, mem_isload;
  logic [4:0]  mem_dst;
  logic [31:0] mem_data;
  logic        wb_wen;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        ex_stall, flush;
  logic        ex_valid, ex_wen, ex_isload;
  logic [31:0] ex_opa, ex_opb;
  logic [4:0]  ex_dst;
  logic [15:0] ex_ctl;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state: what the ID/EX register should hold
  logic        m_valid, m_wen, m_isload;
  logic [31:0] m_opa, m_opb, m_cnt;
  logic [4:0]  m_dst;
  logic [15:0] m_ctl;
  logic [31:0] base;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rea(id_rea), .id_reb(id_reb),
    .id_dst(id_dst), .id_wen(id_wen), .id_isload(id_isload), .id_ctl(id_ctl),
    .rf_raddra(rf_raddra), .rf_raddrb(rf_raddrb), .rf_rea(rf_rea), .rf_reb(rf_reb),
    .rf_rdataa(rf_rdataa), .rf_rdatab(rf_rdatab),
    .mem_wen(mem_wen), .mem_dst(mem_dst), .mem_isload(mem_isload), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_dst(wb_dst), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_dst(ex_dst),
    .ex_wen(ex_wen), .ex_isload(ex_isload), .ex_ctl(ex_ctl), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producers are scanned youngest first; the first one writing src decides.
  function automatic void model_src(input logic [4:0] src, input logic used,
                                    input logic [31:0] rfd,
                                    output logic [31:0] val, output logic hz);
    logic [4:0]  pd [3];
    logic        pw [3];
    logic        pr [3];
    logic [31:0] pv [3];
    pd[0] = m_dst;   pw[0] = m_valid & m_wen; pr[0] = 1'b0;        pv[0] = '0;
    pd[1] = mem_dst; pw[1] = mem_wen;         pr[1] = !mem_isload; pv[1] = mem_data;
    pd[2] = wb_dst;  pw[2] = wb_wen;          pr[2] = 1'b1;        pv[2] = wb_data;
    val = rfd;
    hz  = 1'b0;
    if (src == 5'd0) begin
      val = '0;
      return;
    end
    if (!used) return;
    for (int i = 0; i < 3; i++) begin
      if (pw[i] && pd[i] == src) begin
`ifdef OPERAND_FWD_EN
        if (pr[i]) val = pv[i];
        else       hz  = 1'b1;
`else
        hz = 1'b1;
`endif
        break;
      end
    end
  endfunction

  task automatic tick();
    logic [31:0] va, vb;
    logic        ha, hb, hz;
    #1;
    model_src(id_rs, id_rea, rf_rdataa, va, ha);
    model_src(id_rt, id_reb, rf_rdatab, vb, hb);
    hz = ha | hb;
    chk("id_ready", id_ready, !ex_stall && !hz);
    chk("rf_read_a", {rf_rea, rf_raddra}, {id_valid & id_rea, id_rs});
    chk("rf_read_b", {rf_reb, rf_raddrb}, {id_valid & id_reb, id_rt});
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_wen = 0; m_isload = 0;
      m_opa = 0; m_opb = 0; m_dst = 0; m_ctl = 0; m_cnt = 0;
    end else begin
      if (id_valid && hz && !ex_stall && !flush && m_cnt != 32'hFFFF_FFFF)
        m_cnt = m_cnt + 1;
      if (flush || (!ex_stall && hz)) begin
        m_valid = 0; m_wen = 0; m_isload = 0;
      end else if (!ex_stall) begin
        m_valid  = id_valid;
        m_wen    = id_wen && id_valid;
        m_isload = id_isload && id_valid;
        m_opa = va; m_opb = vb; m_dst = id_dst; m_ctl = id_ctl;
      end
    end
    #1;
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_wen", ex_wen, m_wen);
    chk("ex_isload", ex_isload, m_isload);
    chk("ex_opa", ex_opa, m_opa);
    chk("ex_opb", ex_opb, m_opb);
    chk("ex_dst", ex_dst, m_dst);
    chk("ex_ctl", ex_ctl, m_ctl);
    chk("stall_cnt", stall_cnt, m_cnt);
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic rea,
                        input logic [4:0] rt, input logic reb, input logic [4:0] dst,
                        input logic wen, input logic ld, input logic [15:0] ctl);
    id_valid = v; id_rs = rs; id_rea = rea; id_rt = rt; id_reb = reb;
    id_dst = dst; id_wen = wen; id_isload = ld; id_ctl = ctl;
  endtask

  task automatic clr_prod();
    mem_wen = 0; mem_dst = 0; mem_isload = 0; mem_data = 0;
    wb_wen = 0; wb_dst = 0; wb_data = 0;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    clr_prod();
    tick();
  endtask

  initial begin
    rst = 1; ex_stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    clr_prod();
    rf_rdataa = 0; rf_rdatab = 0;
    m_valid = 0; m_wen = 0; m_isload = 0;
    m_opa = 0; m_opb = 0; m_dst = 0; m_ctl = 0; m_cnt = 0;
    @(posedge clk);
    @(negedge clk);

    // reset wins over flush, stall and a pending instruction
    set_id(1, 3, 1, 4, 1, 6, 1, 1, 16'hBEEF);
    ex_stall = 1; flush = 1; rf_rdataa = 32'h99;
    tick();
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    rst = 0; ex_stall = 0; flush = 0;

    // plain fetch, no producers
    set_id(1, 3, 1, 0, 0, 2, 1, 0, 16'h0C0C);
    rf_rdataa = 32'h11;
    tick();
    chk("basic_valid", ex_valid, 1'b1);
    chk("basic_opa", ex_opa, 32'h11);
    chk("basic_cnt", stall_cnt, 32'd0);
    idle();

    // ALU producer then dependent
    base = m_cnt;
    set_id(1, 1, 1, 2, 1, 5, 1, 0, 16'h1234);
    rf_rdataa = 32'h10; rf_rdatab = 32'h20;
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1, 0, 16'h2222);
    tick();
    mem_wen = 1; mem_dst = 5; mem_isload = 0; mem_data = 32'hAB;
    tick();
`ifdef OPERAND_FWD_EN
    chk("alu_dep_valid", ex_valid, 1'b1);
    chk("alu_dep_opa", ex_opa, 32'hAB);
    chk("alu_dep_cnt", stall_cnt, base + 1);
`endif
    clr_prod();
    wb_wen = 1; wb_dst = 5; wb_data = 32'hAB;
    tick();
    clr_prod();
    rf_rdataa = 32'hAB;
    tick();
`ifndef OPERAND_FWD_EN
    chk("alu_dep_valid", ex_valid, 1'b1);
    chk("alu_dep_opa", ex_opa, 32'hAB);
    chk("alu_dep_cnt", stall_cnt, base + 3);
`endif
    idle();

    // load producer then dependent on rt
    base = m_cnt;
    set_id(1, 1, 1, 0, 0, 7, 1, 1, 16'h3333);
    tick();
    set_id(1, 0, 0, 7, 1, 8, 1, 0, 16'h4444);
    rf_rdatab = 32'h0;
    tick();
    mem_wen = 1; mem_dst = 7; mem_isload = 1; mem_data = 32'hDEAD;
    tick();
    clr_prod();
    wb_wen = 1; wb_dst = 7; wb_data = 32'h55;
    tick();
`ifdef OPERAND_FWD_EN
    chk("load_dep_valid", ex_valid, 1'b1);
    chk("load_dep_opb", ex_opb, 32'h55);
    chk("load_dep_cnt", stall_cnt, base + 2);
`endif
    clr_prod();
    rf_rdatab = 32'h55;
    tick();
`ifndef OPERAND_FWD_EN
    chk("load_dep_opb", ex_opb, 32'h55);
    chk("load_dep_cnt", stall_cnt, base + 3);
`endif
    idle();

    // MEM beats WB; register 0 never forwards
    set_id(1, 9, 1, 0, 0, 0, 0, 0, 16'h5555);
    mem_wen = 1; mem_dst = 9; mem_isload = 0; mem_data = 32'h1;
    wb_wen = 1; wb_dst = 9; wb_data = 32'h2;
    rf_rdataa = 32'h3;
    tick();
`ifdef OPERAND_FWD_EN
    chk("mem_over_wb", ex_opa, 32'h1);
`endif
    idle();
    set_id(1, 0, 1, 0, 0, 0, 1, 0, 16'h6666);
    wb_wen = 1; wb_dst = 0; wb_data = 32'h77;
    rf_rdataa = 32'h33;
    tick();
    chk("r0_valid", ex_valid, 1'b1);
    chk("r0_opa", ex_opa, 32'h0);
    idle();

    // EX stall holds through a hazard; flush beats stall
    set_id(1, 1, 1, 0, 0, 5, 1, 0, 16'h7777);
    tick();
    base = m_cnt;
    set_id(1, 5, 1, 0, 0, 6, 1, 0, 16'h8888);
    ex_stall = 1;
    tick();
    chk("stall_hold_valid", ex_valid, 1'b1);
    chk("stall_hold_dst", ex_dst, 5'd5);
    chk("stall_hold_cnt", stall_cnt, base);
    flush = 1;
    tick();
    chk("flush_over_stall", ex_valid, 1'b0);
    flush = 0; ex_stall = 0;
    idle();

    // WB match on rs
    set_id(1, 4, 1, 0, 0, 1, 0, 0, 16'h9999);
    wb_wen = 1; wb_dst = 4; wb_data = 32'h99;
    rf_rdataa = 32'h44;
    tick();
`ifdef OPERAND_FWD_EN
    chk("wb_match_opa", ex_opa, 32'h99);
`else
    chk("wb_match_bubble", ex_valid, 1'b0);
`endif
    clr_prod();
    tick();
    chk("wb_match_next_valid", ex_valid, 1'b1);
    chk("wb_match_next_opa", ex_opa, 32'h44);

    // random traffic over a small register window to provoke matches
    for (int n = 0; n < 500; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 16'($urandom));
      rf_rdataa  = $urandom; rf_rdatab = $urandom;
      mem_wen    = 1'($urandom); mem_dst = 5'($urandom_range(0, 3));
      mem_isload = 1'($urandom); mem_data = $urandom;
      wb_wen     = 1'($urandom); wb_dst = 5'($urandom_range(0, 3));
      wb_data    = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameters: DW, 32, datapath width; AW, 5, register address width; CW, 16, opaque control bundle width.
REQ-002 SHALL have ports: clk  in  1  clock (rising edge); rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: id_valid in 1, decoded instr present; id_ready out 1, instr accepted this cycle.
REQ-004 SHALL have ports: id_rs, id_rt in AW, sources; id_rea, id_reb in 1, source used; id_dst in AW; id_wen in 1; id_isload in 1; id_ctl in CW.
REQ-005 SHALL have ports: rf_raddra, rf_raddrb out AW; rf_rea, rf_reb out 1; rf_rdataa, rf_rdatab in DW (combinational register-file read).
REQ-006 SHALL have ports: mem_wen in 1, mem_dst in AW, mem_isload in 1, mem_data in DW (MEM-stage result; valid only when !mem_isload).
REQ-007 SHALL have ports: wb_wen in 1, wb_dst in AW, wb_data in DW (same values driven to the register-file write port).
REQ-008 SHALL have ports: ex_stall in 1, EX cannot accept; flush in 1, kill ID/EX contents.
REQ-009 SHALL have registered outputs: ex_valid 1, ex_opa DW, ex_opb DW, ex_dst AW, ex_wen 1, ex_isload 1, ex_ctl CW; stall_cnt out 32, hazard-stall counter.

Function
REQ-010 SHALL drive rf_raddra=id_rs, rf_raddrb=id_rt, rf_rea=id_valid&id_rea, rf_reb=id_valid&id_reb combinationally.
REQ-011 SHALL treat a source as matching a producer only when the source is used, the producer's wen=1, dst==id source, and dst!=0; register 0 never matches and always yields 0.
REQ-012 SHALL raise hazard when any used source matches the held ID/EX entry (ex_valid&ex_wen), since EX results are not yet available.
REQ-013 SHALL raise hazard when a used source matches MEM and mem_isload=1.
REQ-014 SHALL select per operand, priority order: MEM match (non-load) -> mem_data; else WB match -> wb_data; else rf_rdata.
REQ-015 SHALL assert id_ready = !ex_stall & !hazard; id_ready is don't-care-free and defined also when id_valid=0.
REQ-016 SHALL, on a rising edge with flush=1, load a bubble (ex_valid=0, ex_wen=0, ex_isload=0), overriding all else.
REQ-017 SHALL, else with ex_stall=1, hold all ex_* registers unchanged.
REQ-018 SHALL, else with hazard=1, load a bubble (insert one stall cycle); ID instruction stays pending.
REQ-019 SHALL, else load ex_valid=id_valid and capture selected operands, id_dst, id_wen&id_valid, id_isload&id_valid, id_ctl.
REQ-020 SHALL increment stall_cnt by 1 each cycle with id_valid&hazard&!ex_stall&!flush; saturates at 32'hFFFFFFFF.
REQ-021 SHALL give one-cycle ID-to-EX latency; ALU-to-dependent = 1 stall cycle, load-to-dependent = 2 stall cycles.

Reset
REQ-022 SHALL on rst=1 at a rising edge clear ex_valid, ex_wen, ex_isload, ex_opa, ex_opb, ex_dst, ex_ctl, stall_cnt to 0; rst overrides flush and ex_stall.
REQ-023 SHALL, with rst held, present id_ready per REQ-015 from zeroed state (no ID/EX hazard).

Configuration
REQ-024 SHALL honour macro OPERAND_FWD_EN: defined -> REQ-013/014 forwarding as stated.
REQ-025 SHALL, with OPERAND_FWD_EN undefined, raise hazard on any match to ID/EX, MEM or WB and always take rf_rdata; ports unchanged.

Structure
REQ-026 SHALL place DW/AW defaults and REG_ZERO (5'd0) in shared package pcpu_pkg.
REQ-027 SHALL implement per-operand match/select in sub-module operand_fwd_sel, instantiated twice (ports A, B).

Verification
REQ-028 SHALL cover: rst, then id rs=3, rf_rdataa=0x11 with no producers -> next cycle ex_valid=1, ex_opa=0x11, stall_cnt=0.
REQ-029 SHALL cover: ALU op dst=5 then consumer rs=5, mem_data=0xAB -> one bubble, then ex_opa=0xAB, stall_cnt=1.
REQ-030 SHALL cover: load dst=7 then consumer rt=7 -> two bubbles, third cycle ex_opb=wb_data=0x55 (regfile returns stale 0x0).
REQ-031 SHALL cover: mem_dst=wb_dst=9, mem_data=0x1, wb_data=0x2 -> ex_opa=0x1; source 0 with wb_dst=0, wb_wen=1 -> ex_opa=0.
REQ-032 SHALL cover: ex_stall=1 with hazard -> ex_* held, stall_cnt unchanged; flush=1 with ex_stall=1 -> ex_valid=0 next cycle.
REQ-033 SHALL cover: build without OPERAND_FWD_EN, WB match on rs -> one bubble, then ex_opa=rf_rdataa.
